// File: rtl/hdmi_config_sequencer.sv
// hdmi_config_sequencer
//
// Walks an external configuration table of {register address, data} pairs
// and issues one I2C write per entry to the HDMI transmitter through the
// I2C write engine's request/acknowledge/done handshake. NACKed writes are
// re-issued after a back-off delay, up to MAX_RETRIES times per entry.
// Overall completion or failure is reported to the video pipeline as
// level flags.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous active-high reset
//   configStart      single-cycle start pulse (honoured in IDLE/DONE/ERROR)
//   tableIndex       address into the configuration table
//   tableData        combinational table read: [15:8] reg address, [7:0] data
//   i2cReq           write request to the I2C engine
//   i2cAck           engine accepted the request (one-cycle pulse)
//   i2cDone          transfer finished (one-cycle pulse)
//   i2cNack          valid with i2cDone, high when the slave NACKed
//   i2cSlaveAddress  constant SLAVE_ADDRESS
//   i2cRegAddress    register address of the current write
//   i2cData          data byte of the current write
//   configBusy       sequence in progress
//   configDone       level, table completed
//   configError      level, an entry exhausted its retries
//   errorIndex       index of the failing entry, 0 otherwise

module hdmi_config_sequencer #(
    parameter logic [7:0]  SLAVE_ADDRESS = 8'h72,
    parameter int          INDEX_WIDTH   = 5,
    parameter logic [15:0] STARTUP_DELAY = 16'd2000,
    parameter logic [15:0] RETRY_DELAY   = 16'd100,
    parameter int          MAX_RETRIES   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   configStart,
    output logic [INDEX_WIDTH-1:0] tableIndex,
    input  logic [15:0]            tableData,
    output logic                   i2cReq,
    input  logic                   i2cAck,
    input  logic                   i2cDone,
    input  logic                   i2cNack,
    output logic [7:0]             i2cSlaveAddress,
    output logic [7:0]             i2cRegAddress,
    output logic [7:0]             i2cData,
    output logic                   configBusy,
    output logic                   configDone,
    output logic                   configError,
    output logic [INDEX_WIDTH-1:0] errorIndex
);

    localparam int RETRY_WIDTH = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = '1;
    localparam logic [15:0]            TERMINATOR  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        STARTUP,
        FETCH,
        REQUEST,
        WAIT_DONE,
        BACKOFF,
        DONE,
        ERROR
    } state_t;

    state_t                   state_q;
    logic [15:0]              delayCnt_q;
    logic [RETRY_WIDTH-1:0]   retryCnt_q;
    logic [INDEX_WIDTH-1:0]   tableIndex_q;
    logic [INDEX_WIDTH-1:0]   errorIndex_q;
    logic [7:0]               regAddr_q;
    logic [7:0]               data_q;
    logic                     req_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     error_q;

    logic [INDEX_WIDTH-1:0]   nextIndex_d;

    assign nextIndex_d = tableIndex_q + 1'b1;

    // Single FSM; every output is a register so nothing on an input reaches
    // an output combinationally. i2cReq is set on the transition into
    // REQUEST so it is high for exactly the cycles spent in REQUEST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            delayCnt_q   <= '0;
            retryCnt_q   <= '0;
            tableIndex_q <= '0;
            errorIndex_q <= '0;
            regAddr_q    <= '0;
            data_q       <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (configStart) begin
                        tableIndex_q <= '0;
                        retryCnt_q   <= '0;
                        errorIndex_q <= '0;
                        delayCnt_q   <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        // A zero start-up delay skips the wait entirely so
                        // FETCH still lands on cycle STARTUP_DELAY+1.
                        state_q      <= (STARTUP_DELAY == 16'd0) ? FETCH : STARTUP;
                    end
                end

                STARTUP: begin
                    if (delayCnt_q == STARTUP_DELAY - 16'd1) begin
                        state_q <= FETCH;
                    end else begin
                        delayCnt_q <= delayCnt_q + 16'd1;
                    end
                end

                FETCH: begin
                    regAddr_q <= tableData[15:8];
                    data_q    <= tableData[7:0];
                    if (tableData == TERMINATOR) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= REQUEST;
                        req_q   <= 1'b1;
                    end
                end

                REQUEST: begin
                    if (i2cAck) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (i2cDone) begin
                        if (!i2cNack) begin
                            // The all-ones entry is terminal; the index
                            // never wraps back to zero.
                            if (tableIndex_q == LAST_INDEX) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                tableIndex_q <= nextIndex_d;
                                retryCnt_q   <= '0;
                                state_q      <= FETCH;
                            end
                        end else if (retryCnt_q < RETRY_LIMIT) begin
                            retryCnt_q <= retryCnt_q + 1'b1;
                            delayCnt_q <= '0;
                            if (RETRY_DELAY == 16'd0) begin
                                state_q <= REQUEST;
                                req_q   <= 1'b1;
                            end else begin
                                state_q <= BACKOFF;
                            end
                        end else begin
                            errorIndex_q <= tableIndex_q;
                            state_q      <= ERROR;
                            busy_q       <= 1'b0;
                            error_q      <= 1'b1;
                        end
                    end
                end

                BACKOFF: begin
                    // Address and data registers still hold the NACKed
                    // entry, so the retry goes straight back to REQUEST.
                    if (delayCnt_q == RETRY_DELAY - 16'd1) begin
                        state_q <= REQUEST;
                        req_q   <= 1'b1;
                    end else begin
                        delayCnt_q <= delayCnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tableIndex      = tableIndex_q;
    assign errorIndex      = errorIndex_q;
    assign i2cReq          = req_q;
    assign i2cSlaveAddress = SLAVE_ADDRESS;
    assign i2cRegAddress   = regAddr_q;
    assign i2cData         = data_q;
    assign configBusy      = busy_q;
    assign configDone      = done_q;
    assign configError     = error_q;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// tb_hdmi_config_sequencer
//
// Directed bench for hdmi_config_sequencer. A 32-entry instance
// (STARTUP_DELAY=4, RETRY_DELAY=2, MAX_RETRIES=3) covers the basic table,
// retries, exhaustion, restart and reset; a 4-entry instance covers running
// off the end of a table with no terminator. Both instances share the
// engine-side inputs; useSmall selects which one is observed.

module tb_hdmi_config_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic configStart = 1'b0;
    logic i2cAck = 1'b0;
    logic i2cDone = 1'b0;
    logic i2cNack = 1'b0;

    logic [4:0]  tableIndex, errorIndex;
    logic [15:0] tableData;
    logic        i2cReq, configBusy, configDone, configError;
    logic [7:0]  i2cSlaveAddress, i2cRegAddress, i2cData;

    logic [1:0]  smTableIndex, smErrorIndex;
    logic [15:0] smTableData;
    logic        smReq, smBusy, smDone, smError;
    logic [7:0]  smSlave, smRegAddress, smData;

    logic [15:0] tableMem [0:31];
    logic [15:0] smMem [0:3];

    logic        useSmall = 1'b0;
    logic        obsReq, obsBusy, obsDone, obsError;
    logic [4:0]  obsIdx, obsErrIdx;
    logic [7:0]  obsSlave, obsReg, obsData;

    int vectorCount = 0;
    int missCount = 0;
    int writesSeen = 0;

    always #5 clk = ~clk;

    assign tableData   = tableMem[tableIndex];
    assign smTableData = smMem[smTableIndex];

    hdmi_config_sequencer #(
        .SLAVE_ADDRESS(8'h72), .INDEX_WIDTH(5), .STARTUP_DELAY(16'd4),
        .RETRY_DELAY(16'd2), .MAX_RETRIES(3)
    ) dut (
        .clk(clk), .reset(reset), .configStart(configStart),
        .tableIndex(tableIndex), .tableData(tableData),
        .i2cReq(i2cReq), .i2cAck(i2cAck), .i2cDone(i2cDone), .i2cNack(i2cNack),
        .i2cSlaveAddress(i2cSlaveAddress), .i2cRegAddress(i2cRegAddress),
        .i2cData(i2cData), .configBusy(configBusy), .configDone(configDone),
        .configError(configError), .errorIndex(errorIndex)
    );

    hdmi_config_sequencer #(
        .SLAVE_ADDRESS(8'h72), .INDEX_WIDTH(2), .STARTUP_DELAY(16'd4),
        .RETRY_DELAY(16'd2), .MAX_RETRIES(3)
    ) dutSmall (
        .clk(clk), .reset(reset), .configStart(configStart),
        .tableIndex(smTableIndex), .tableData(smTableData),
        .i2cReq(smReq), .i2cAck(i2cAck), .i2cDone(i2cDone), .i2cNack(i2cNack),
        .i2cSlaveAddress(smSlave), .i2cRegAddress(smRegAddress),
        .i2cData(smData), .configBusy(smBusy), .configDone(smDone),
        .configError(smError), .errorIndex(smErrorIndex)
    );

    // Observation mux so the same tasks can drive either instance.
    always_comb begin
        obsReq    = useSmall ? smReq : i2cReq;
        obsBusy   = useSmall ? smBusy : configBusy;
        obsDone   = useSmall ? smDone : configDone;
        obsError  = useSmall ? smError : configError;
        obsIdx    = useSmall ? {3'b000, smTableIndex} : tableIndex;
        obsErrIdx = useSmall ? {3'b000, smErrorIndex} : errorIndex;
        obsSlave  = useSmall ? smSlave : i2cSlaveAddress;
        obsReg    = useSmall ? smRegAddress : i2cRegAddress;
        obsData   = useSmall ? smData : i2cData;
    end

    // Counts writes accepted by the engine (request high while ack sampled).
    always @(posedge clk) begin
        if (obsReq && i2cAck) writesSeen <= writesSeen + 1;
    end

    typedef struct packed {
        logic       start;
        logic       ack;
        logic       done;
        logic       nack;
        logic       req;
        logic       busy;
        logic       doneFlag;
        logic       err;
        logic [4:0] idx;
        logic [7:0] regAddr;
        logic [7:0] data;
    } vector_t;

    vector_t vecs [0:14];

    function automatic vector_t mkVec(input logic s, input logic a, input logic d,
                                      input logic n, input logic r, input logic b,
                                      input logic dn, input logic e, input logic [4:0] idx,
                                      input logic [7:0] ra, input logic [7:0] dt);
        vector_t v;
        v.start = s; v.ack = a; v.done = d; v.nack = n;
        v.req = r; v.busy = b; v.doneFlag = dn; v.err = e;
        v.idx = idx; v.regAddr = ra; v.data = dt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        configStart = v.start;
        i2cAck      = v.ack;
        i2cDone     = v.done;
        i2cNack     = v.nack;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        configStart = 1'b0; i2cAck = 1'b0; i2cDone = 1'b0; i2cNack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 1 (cycle 0 = start sampled).
    task automatic pulseStart();
        configStart = 1'b1;
        @(negedge clk);
        configStart = 1'b0;
    endtask

    // Waits (bounded) for a request, acks it, then completes it one cycle
    // later with the given NACK bit. Returns at the negedge after the done
    // cycle. waited = negedges spent waiting for the request.
    task automatic doWrite(input logic nackBit, output int waited,
                           output logic [7:0] gotReg, output logic [7:0] gotData,
                           output logic [4:0] gotIdx);
        waited = 0;
        while (!obsReq && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        gotReg = obsReg; gotData = obsData; gotIdx = obsIdx;
        if (!obsReq) begin
            checkOutput("reqTimeout", 32'd0, 32'd1);
        end else begin
            i2cAck = 1'b1;
            @(negedge clk);
            i2cAck = 1'b0;
            i2cDone = 1'b1; i2cNack = nackBit;
            @(negedge clk);
            i2cDone = 1'b0; i2cNack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int wBase;
        logic [7:0] gotReg, gotData;
        logic [4:0] gotIdx;
        logic sawReq;

        for (int i = 0; i < 32; i++) tableMem[i] = 16'hFFFF;
        tableMem[0] = 16'h4110;
        tableMem[1] = 16'h9803;
        smMem[0] = 16'h1101; smMem[1] = 16'h2202;
        smMem[2] = 16'h3303; smMem[3] = 16'h4404;

        //             st ack dn nk  req bsy dn er idx reg    data
        vecs[0]  = mkVec(1, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[1]  = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[2]  = mkVec(1, 0, 0, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[3]  = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[4]  = mkVec(0, 1, 1, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[5]  = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[6]  = mkVec(0, 1, 0, 0,  1, 1, 0, 0, 0, 8'h41, 8'h10);
        vecs[7]  = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h41, 8'h10);
        vecs[8]  = mkVec(0, 0, 1, 0,  0, 1, 0, 0, 0, 8'h41, 8'h10);
        vecs[9]  = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 1, 8'h41, 8'h10);
        vecs[10] = mkVec(0, 1, 0, 0,  1, 1, 0, 0, 1, 8'h98, 8'h03);
        vecs[11] = mkVec(0, 0, 1, 0,  0, 1, 0, 0, 1, 8'h98, 8'h03);
        vecs[12] = mkVec(0, 0, 0, 0,  0, 1, 0, 0, 2, 8'h98, 8'h03);
        vecs[13] = mkVec(0, 0, 0, 0,  0, 0, 1, 0, 2, 8'hFF, 8'hFF);
        vecs[14] = mkVec(0, 0, 0, 0,  0, 0, 1, 0, 2, 8'hFF, 8'hFF);

        // Basic table, cycle by cycle. Stray start/ack/done in STARTUP
        // (vectors 2 and 4) must be ignored.
        resetDut();
        checkOutput("resetSlave", obsSlave, 8'h72);
        checkOutput("resetErrIdx", obsErrIdx, 5'd0);
        wBase = writesSeen;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            checkOutput($sformatf("vec%0d.req", t), obsReq, vecs[t].req);
            checkOutput($sformatf("vec%0d.busy", t), obsBusy, vecs[t].busy);
            checkOutput($sformatf("vec%0d.done", t), obsDone, vecs[t].doneFlag);
            checkOutput($sformatf("vec%0d.err", t), obsError, vecs[t].err);
            checkOutput($sformatf("vec%0d.idx", t), obsIdx, vecs[t].idx);
            checkOutput($sformatf("vec%0d.reg", t), obsReg, vecs[t].regAddr);
            checkOutput($sformatf("vec%0d.data", t), obsData, vecs[t].data);
            applyStimulus(vecs[t]);
        end
        checkOutput("basicWriteCount", writesSeen - wBase, 2);
        checkOutput("basicSlave", obsSlave, 8'h72);

        // Single retry on entry 0.
        resetDut();
        pulseStart();
        doWrite(1'b1, waited, gotReg, gotData, gotIdx);
        checkOutput("retryFirstReqCycle", 1 + waited, 6);
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        checkOutput("retryReissueDelay", 1 + waited, 3);
        checkOutput("retryReg", gotReg, 8'h41);
        checkOutput("retryData", gotData, 8'h10);
        checkOutput("retryIdx", gotIdx, 5'd0);
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        checkOutput("retryNextReqDelay", 1 + waited, 2);
        checkOutput("retryEntry1Reg", gotReg, 8'h98);
        checkOutput("retryEntry1Data", gotData, 8'h03);
        @(negedge clk);
        checkOutput("retryDone", obsDone, 1'b1);
        checkOutput("retryBusy", obsBusy, 1'b0);

        // Retry exhaustion on entry 1.
        resetDut();
        wBase = writesSeen;
        pulseStart();
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        for (int a = 0; a < 4; a++) begin
            doWrite(1'b1, waited, gotReg, gotData, gotIdx);
            checkOutput($sformatf("exhaustIdx%0d", a), gotIdx, 5'd1);
            if (a < 3) checkOutput($sformatf("exhaustNoErr%0d", a), obsError, 1'b0);
        end
        checkOutput("exhaustError", obsError, 1'b1);
        checkOutput("exhaustErrIdx", obsErrIdx, 5'd1);
        checkOutput("exhaustDone", obsDone, 1'b0);
        checkOutput("exhaustBusy", obsBusy, 1'b0);
        sawReq = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (obsReq) sawReq = 1'b1;
        end
        checkOutput("exhaustNoFifthReq", sawReq, 1'b0);
        checkOutput("exhaustWriteCount", writesSeen - wBase, 5);

        // Full 4-entry table with no terminator.
        useSmall = 1'b1;
        resetDut();
        wBase = writesSeen;
        pulseStart();
        for (int e = 0; e < 4; e++) begin
            doWrite(1'b0, waited, gotReg, gotData, gotIdx);
            checkOutput($sformatf("fullIdx%0d", e), gotIdx, e);
            checkOutput($sformatf("fullReg%0d", e), gotReg, 8'h11 * (e + 1));
            checkOutput($sformatf("fullData%0d", e), gotData, e + 1);
        end
        checkOutput("fullDone", obsDone, 1'b1);
        checkOutput("fullBusy", obsBusy, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("fullIdxHeld", obsIdx, 5'd3);
        checkOutput("fullDoneHeld", obsDone, 1'b1);
        checkOutput("fullWriteCount", writesSeen - wBase, 4);
        useSmall = 1'b0;

        // Start ignored in WAIT_DONE, then restart after DONE.
        resetDut();
        pulseStart();
        waited = 0;
        while (!obsReq && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ignoreReqSeen", obsReq, 1'b1);
        i2cAck = 1'b1;
        @(negedge clk);
        i2cAck = 1'b0;
        configStart = 1'b1;
        @(negedge clk);
        configStart = 1'b0;
        checkOutput("ignoreBusy", obsBusy, 1'b1);
        checkOutput("ignoreReq", obsReq, 1'b0);
        i2cDone = 1'b1;
        @(negedge clk);
        i2cDone = 1'b0;
        checkOutput("ignoreAdvanced", obsIdx, 5'd1);
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        checkOutput("ignoreEntry1Reg", gotReg, 8'h98);
        @(negedge clk);
        checkOutput("ignoreDone", obsDone, 1'b1);
        pulseStart();
        checkOutput("restartDoneClr", obsDone, 1'b0);
        checkOutput("restartBusy", obsBusy, 1'b1);
        checkOutput("restartIdx", obsIdx, 5'd0);
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        checkOutput("restartFirstReq", 1 + waited, 6);
        checkOutput("restartReg", gotReg, 8'h41);
        doWrite(1'b0, waited, gotReg, gotData, gotIdx);
        checkOutput("restartReg1", gotReg, 8'h98);
        @(negedge clk);
        checkOutput("restartDone", obsDone, 1'b1);

        // Reset asserted while in REQUEST.
        resetDut();
        pulseStart();
        waited = 0;
        while (!obsReq && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rstReqSeen", obsReq, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstReqLow", obsReq, 1'b0);
        checkOutput("rstBusyLow", obsBusy, 1'b0);
        checkOutput("rstRegCleared", obsReg, 8'h00);
        i2cDone = 1'b1;
        @(negedge clk);
        i2cDone = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstLateDoneBusy", obsBusy, 1'b0);
        checkOutput("rstLateDoneReq", obsReq, 1'b0);
        checkOutput("rstLateDoneDone", obsDone, 1'b0);
        checkOutput("rstLateDoneIdx", obsIdx, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
